decode_source_arbiter: RTL

- Shares one packet decode FSM between two 32-bit word sources: src0 is the UART word assembler and src1 is the FT245/USB word assembler.
- Grants the decoder to one source per packet, starting at START_OF_PACKET.
- Holds the grant until the decoder reports the packet fully decoded, the owner resyncs, or a timeout fires. On timeout it injects a RESYNC word so the decoder cannot stall on a dead source.
- Sits between the word assemblers and the decoder's i_recv_word_cmd / i_recv_word_data inputs.

---
 rtl/decode_source_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/decode_source_arbiter.sv
// decode_source_arbiter
// Shares one packet decode FSM between the UART word assembler (src0) and the
// FT245/USB word assembler (src1). A source wins the decoder by presenting
// START_OF_PACKET and keeps it until the decoder reports the packet done, the
// owner resyncs, or the owner goes quiet for TIMEOUT_CYCLES cycles. In the
// timeout case a RESYNC word is injected so the decoder cannot stall.
// TIMEOUT_CYCLES must fit in TIMEOUT_W bits.
// Optional feature macro: DECODE_ARB_DROP_COUNT_EN enables the saturating
// dropped-word counter on o_drop_count. When it is undefined the port reads 0.
module decode_source_arbiter #(
   parameter int TIMEOUT_W      = 24,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_src0_word_valid,
   input  logic [31:0] i_src0_word_data,
   input  logic        i_src1_word_valid,
   input  logic [31:0] i_src1_word_data,
   input  logic        i_packet_fully_decoded,
   output logic        o_word_cmd,
   output logic [31:0] o_word_data,
   output logic [1:0]  o_grant,
   output logic        o_timeout,
   output logic [15:0] o_drop_count
);

   localparam logic [31:0] RESYNC = 32'h1EDC6F41;
   localparam logic [31:0] SOP    = 32'h741B8CD7;
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {sIDLE, sLOCK, sFLUSH} state_t;

   state_t               state, state_n;
   logic                 owner, owner_n;
   logic                 rr_ptr, rr_n;
   logic [2:0]           fwd_cnt, fwd_n;
   logic [TIMEOUT_W-1:0] tmo_cnt, tmo_n;
   logic                 word_cmd_n;
   logic [31:0]          word_data_n;
   logic [1:0]           grant_n;
   logic                 timeout_n;

   logic                 sop0, sop1, res0, res1;
   logic                 sop_win;
   logic                 owner_valid;
   logic [31:0]          owner_data;
   logic                 done_ok;

   assign sop0 = i_src0_word_valid && (i_src0_word_data == SOP);
   assign sop1 = i_src1_word_valid && (i_src1_word_data == SOP);
   assign res0 = i_src0_word_valid && (i_src0_word_data == RESYNC);
   assign res1 = i_src1_word_valid && (i_src1_word_data == RESYNC);

   // On a tie the source that did not own the last packet wins
   assign sop_win     = (sop0 && sop1) ? ~rr_ptr : sop1;
   assign owner_valid = owner ? i_src1_word_valid : i_src0_word_valid;
   assign owner_data  = owner ? i_src1_word_data  : i_src0_word_data;
   // The done level is only believed once a full packet header has passed
   assign done_ok     = i_packet_fully_decoded && (fwd_cnt == 3'd4);

   // State, arbitration bookkeeping and registered decoder-facing outputs
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= sIDLE;
         owner       <= 1'b0;
         rr_ptr      <= 1'b1;
         fwd_cnt     <= 3'd0;
         tmo_cnt     <= '0;
         o_word_cmd  <= 1'b0;
         o_word_data <= 32'd0;
         o_grant     <= 2'b00;
         o_timeout   <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         rr_ptr      <= rr_n;
         fwd_cnt     <= fwd_n;
         tmo_cnt     <= tmo_n;
         o_word_cmd  <= word_cmd_n;
         o_word_data <= word_data_n;
         o_grant     <= grant_n;
         o_timeout   <= timeout_n;
      end
   end

   // Next-state decode: who owns the decoder and which word goes to it
   always_comb begin
      state_n     = state;
      owner_n     = owner;
      rr_n        = rr_ptr;
      fwd_n       = fwd_cnt;
      tmo_n       = tmo_cnt;
      word_cmd_n  = 1'b0;
      word_data_n = 32'd0;
      grant_n     = o_grant;
      timeout_n   = 1'b0;
      case (state)
         sIDLE: begin
            if (sop0 || sop1) begin
               state_n     = sLOCK;
               owner_n     = sop_win;
               grant_n     = sop_win ? 2'b10 : 2'b01;
               fwd_n       = 3'd1;
               tmo_n       = '0;
               word_cmd_n  = 1'b1;
               word_data_n = SOP;
            end else if (res0 || res1) begin
               word_cmd_n  = 1'b1;
               word_data_n = RESYNC;
            end
         end
         sLOCK: begin
            if (owner_valid) begin
               word_cmd_n  = 1'b1;
               word_data_n = owner_data;
               fwd_n       = (fwd_cnt == 3'd4) ? 3'd4 : fwd_cnt + 3'd1;
               tmo_n       = '0;
               if (owner_data == RESYNC) begin
                  state_n = sIDLE;
                  grant_n = 2'b00;
               end else if (done_ok) begin
                  state_n = sIDLE;
                  grant_n = 2'b00;
                  rr_n    = owner;
               end
            end else if (done_ok) begin
               state_n = sIDLE;
               grant_n = 2'b00;
               rr_n    = owner;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
               state_n     = sFLUSH;
               grant_n     = 2'b00;
               word_cmd_n  = 1'b1;
               word_data_n = RESYNC;
               timeout_n   = 1'b1;
            end else begin
               tmo_n = tmo_cnt + TIMEOUT_W'(1);
            end
         end
         sFLUSH: begin
            state_n = sIDLE;
            grant_n = 2'b00;
            rr_n    = owner;
         end
         default: begin
            state_n = sIDLE;
            grant_n = 2'b00;
         end
      endcase
   end

`ifdef DECODE_ARB_DROP_COUNT_EN
   logic        other_valid;
   logic [1:0]  drop_inc;
   logic [16:0] drop_sum;
   logic [15:0] drop_cnt;

   assign other_valid = owner ? i_src0_word_valid : i_src1_word_valid;

   // Number of words discarded this cycle (0, 1 or 2)
   always_comb begin
      drop_inc = 2'd0;
      case (state)
         sIDLE: begin
            if (sop0 || sop1)
               drop_inc = {1'b0, sop_win ? i_src0_word_valid : i_src1_word_valid};
            else if (res0 || res1)
               drop_inc = {1'b0, i_src0_word_valid && !res0} + {1'b0, i_src1_word_valid && !res1};
            else
               drop_inc = {1'b0, i_src0_word_valid} + {1'b0, i_src1_word_valid};
         end
         sLOCK:   drop_inc = {1'b0, other_valid};
         sFLUSH:  drop_inc = {1'b0, i_src0_word_valid} + {1'b0, i_src1_word_valid};
         default: drop_inc = 2'd0;
      endcase
   end

   assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

   // Saturating drop counter, cleared only by reset
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         drop_cnt <= 16'd0;
      else
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   assign o_drop_count = drop_cnt;
`else
   assign o_drop_count = 16'd0;
`endif

endmodule
